// File: rtl/rr_mux8.sv
// Eight-channel round-robin multiplexer with a registered valid/ready output stage.
// Define RR_MUX8_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module rr_mux8 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  input  logic               out_ready
);

  logic             load;
  logic             grant_valid;
  logic [2:0]       grant;
  logic [2:0]       base;
  logic [2:0]       idx;
  logic [WIDTH-1:0] grant_data;

`ifdef RR_MUX8_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [2:0] ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load && grant_valid) begin
      ptr <= grant + 3'd1;
    end
  end

  assign base = ptr;
`endif

  assign load = en & ~rst & (~out_valid | out_ready);

  // Scan from base upward (mod 8); the first requester found wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = base + 3'(i);
      if (!grant_valid && in_valid[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

  always_comb begin
    grant_data = in_data[grant*WIDTH +: WIDTH];
    in_ready   = '0;
    if (load && grant_valid) begin
      in_ready = 8'b1 << grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load && grant_valid) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_sel   <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux8.sv
// Directed bench for rr_mux8: reset, single channel, contention/wrap, backpressure, enable, reset.
module tb_rr_mux8;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [7:0]         in_valid;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic               out_ready;

  int checks   = 0;
  int failures = 0;

  rr_mux8 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] exp_sel;

    rst       = 1'b1;
    en        = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();

    // Reset state; requests during reset get no in_ready
    en       = 1'b1;
    in_valid = 8'hFF;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data",  32'(out_data),  32'h00);
    check("rst_out_sel",   32'(out_sel),   32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h00);

    // Single channel
    in_valid  = 8'b0000_0100;
    in_data   = '0;
    in_data[2*WIDTH +: WIDTH] = 8'hA5;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("single_in_ready", 32'(in_ready), 32'h04);
    tick();
    in_valid = '0;
    #1;
    check("single_out_valid", 32'(out_valid), 32'h1);
    check("single_out_data",  32'(out_data),  32'hA5);
    check("single_out_sel",   32'(out_sel),   32'h2);
    check("single_in_ready0", 32'(in_ready),  32'h00);
    tick();
    check("single_drain_valid", 32'(out_valid), 32'h0);
    check("single_hold_data",   32'(out_data),  32'hA5);
    check("single_hold_sel",    32'(out_sel),   32'h2);

    // Full contention and wrap, starting from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) in_data[k*WIDTH +: WIDTH] = 8'(k + 'h10);
    in_valid = 8'hFF;
    for (int j = 0; j < 9; j++) begin
`ifdef RR_MUX8_FIXED_PRIO_EN
      exp_sel = 3'd0;
`else
      exp_sel = 3'(j % 8);
`endif
      #1;
      check("rr_in_ready", 32'(in_ready), 32'(8'b1 << exp_sel));
      tick();
      check("rr_out_valid", 32'(out_valid), 32'h1);
      check("rr_out_sel",   32'(out_sel),   32'(exp_sel));
      check("rr_out_data",  32'(out_data),  32'(exp_sel) + 32'h10);
    end

    // Backpressure: load ch3, then stall three cycles
    in_valid = 8'b0001_1000;
    #1;
    check("bp_grant3", 32'(in_ready), 32'h08);
    tick();
    in_valid  = 8'b0001_0000;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_in_ready", 32'(in_ready),  32'h00);
      check("bp_valid",    32'(out_valid), 32'h1);
      check("bp_sel",      32'(out_sel),   32'h3);
      check("bp_data",     32'(out_data),  32'h13);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h10);
    tick();
    check("bp_next_sel",  32'(out_sel),  32'h4);
    check("bp_next_data", 32'(out_data), 32'h14);

    // Enable gating while ch5/ch6 request
    in_valid = 8'b0110_0000;
    en       = 1'b0;
    #1;
    check("en_in_ready0", 32'(in_ready), 32'h00);
    tick();
    check("en_drained", 32'(out_valid), 32'h0);
    tick();
    check("en_still_idle", 32'(out_valid), 32'h0);
    check("en_in_ready1",  32'(in_ready),  32'h00);
    en = 1'b1;
    #1;
    check("en_grant5", 32'(in_ready), 32'h20);
    tick();
    check("en_sel",   32'(out_sel),   32'h5);
    check("en_data",  32'(out_data),  32'h15);
    check("en_valid", 32'(out_valid), 32'h1);

    // Reset mid-transfer with ch1..ch7 requesting
    in_valid  = 8'hFE;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    check("mrst_in_ready", 32'(in_ready), 32'h00);
    tick();
    rst = 1'b0;
    check("mrst_valid", 32'(out_valid), 32'h0);
    check("mrst_sel",   32'(out_sel),   32'h0);
    check("mrst_data",  32'(out_data),  32'h00);
    #1;
    check("mrst_grant1", 32'(in_ready), 32'h02);
    tick();
    check("mrst_out_sel",  32'(out_sel),  32'h1);
    check("mrst_out_data", 32'(out_data), 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux8.md
# rr_mux8

Eight-channel round-robin multiplexer with a registered valid/ready output. It collects data from eight independent producers and serialises it onto one output stream. Each output word is tagged with a 3-bit source index, so the existing 8-way demultiplexer at the far end can steer it back to the matching channel. It sits at the merge point of a channelised datapath, in front of the shared link or buffer.

## Interface
- `WIDTH`, 8, data width of each channel and of the output.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  grant enable; 0 blocks new grants, and a word already held on the output still drains.
- `in_valid`  in  8  per-channel request; bit k means channel k presents data.
- `in_data`  in  8*WIDTH  channel k data on bits [k*WIDTH +: WIDTH].
- `in_ready`  out  8  one-hot accept strobe; bit k high means channel k is consumed this cycle.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  WIDTH  registered data of the granted channel.
- `out_sel`  out  3  index of the channel that produced `out_data`.
- `out_ready`  in  1  downstream accepts the word this cycle.

## Operation
- State:
  - output register: `out_valid`, `out_data`, `out_sel`.
  - 3-bit priority pointer `ptr`.
- Load condition: `load = en & ~rst & (~out_valid | out_ready)`.
- Arbitration (combinational):
  - Search channels in order ptr, ptr+1, …, ptr+7, all modulo 8.
  - The first k with `in_valid[k]=1` wins.
  - If no request is set, there is no grant.
- `in_ready`:
  - `in_ready[k] = load & grant==k`.
  - Never more than one bit high at a time.
  - All zero while `en=0` or `rst=1`.
- On a clock edge with a grant to channel k:
  - `out_data <= in_data[k]`, `out_sel <= k`, `out_valid <= 1`.
  - `ptr <= k+1` modulo 8, so 7 wraps to 0.
- On a clock edge with `out_valid & out_ready` and no new grant:
  - `out_valid <= 0`.
  - `out_data` and `out_sel` hold their last values.
- With `out_valid=1` and `out_ready=0`:
  - The output register is frozen.
  - No grant is issued and `ptr` holds.
- `ptr` advances only when a grant occurs; idle cycles leave it unchanged.
- Producers must hold `in_valid[k]` and `in_data[k]` stable until they see `in_ready[k]`. The block does not check this.
- A channel that drops `in_valid` before it is granted is skipped; there is no error.

## Timing
- Reset values (held one cycle after `rst` falls):
  - `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`, `in_ready=0`.
- Latency: a request granted at edge N appears with `out_valid=1` in cycle N+1.
- Throughput: one word per cycle while `out_ready=1` and requests are pending. Consume and reload happen on the same edge, with no bubble.
- Simultaneous requests: the round-robin order is guaranteed. With all eight requesting continuously, the grants after reset are 0,1,2,…,7,0,…
- `en` falling: it takes effect in the same cycle (`in_ready` drops combinationally). A word already held still completes normally.
- `rst` asserted mid-transfer: the held word is discarded. Outputs return to their reset values on the next edge, and no `in_ready` is issued during reset.

## Configuration
- Macro: `RR_MUX8_FIXED_PRIO_EN`.
- Undefined (default): round-robin as described above.
- Defined:
  - Fixed priority; the lowest-index requesting channel always wins.
  - `ptr` is removed, or tied to 0 and never updated.
  - Ports, latency and handshake rules are unchanged.

## Test plan
- Single channel: after reset, `in_valid=8'b0000_0100` with ch2 data 8'hA5, `out_ready=1`, `en=1`:
  - `in_ready=8'b0000_0100` for one cycle.
  - Next cycle `out_valid=1`, `out_data=8'hA5`, `out_sel=3'd2`.
- Full contention and wrap:
  - `in_valid=8'hFF` held, with channel k data = k+8'h10, `out_ready=1`.
  - `out_sel` sequence is 0..7 then 0 again, one word per cycle.
  - Data matches the selected channel.
- Backpressure:
  - Hold `out_ready=0` for 3 cycles while `out_valid=1` (`out_sel=3`).
  - `out_data` and `out_sel` stay stable and `in_ready=0`.
  - On release, the next grant goes to ch4 if it is requesting.
- Enable gating: drop `en` while ch5 and ch6 are requesting.
  - `in_ready=0` and the held word drains.
  - `out_valid` goes 0 and stays 0 until `en=1` again.
  - The next grant is ch5.
- Reset mid-operation:
  - Assert `rst` for 1 cycle while `out_valid=1` and ch1–ch7 are requesting.
  - After the reset edge: `out_valid=0`, `out_sel=0`, `ptr=0`.
  - The first grant afterwards goes to the lowest requester (ch1).
- With `RR_MUX8_FIXED_PRIO_EN` and `in_valid=8'hFF` held: ch0 is granted every cycle.
